// File: rtl/redop_stream_reducer_pkg.sv
// rtl/redop_stream_reducer_pkg.sv - opcode encodings, FSM states and result evaluation for redop_stream_reducer
package redop_stream_reducer_pkg;

    localparam logic [2:0] REDOP_AND  = 3'd0;
    localparam logic [2:0] REDOP_OR   = 3'd1;
    localparam logic [2:0] REDOP_NAND = 3'd2;
    localparam logic [2:0] REDOP_NOR  = 3'd3;
    localparam logic [2:0] REDOP_XOR  = 3'd4;
    localparam logic [2:0] REDOP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Returns {err, bit}; illegal opcodes force the bit low.
    function automatic logic [1:0] redop_eval(input logic [2:0] op,
                                              input logic       acc_and,
                                              input logic       acc_or,
                                              input logic       acc_xor);
        logic [1:0] r;
        r = 2'b00;
        case (op)
            REDOP_AND:  r = {1'b0, acc_and};
            REDOP_OR:   r = {1'b0, acc_or};
            REDOP_NAND: r = {1'b0, ~acc_and};
            REDOP_NOR:  r = {1'b0, ~acc_or};
            REDOP_XOR:  r = {1'b0, acc_xor};
            REDOP_XNOR: r = {1'b0, ~acc_xor};
            default:    r = 2'b10;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/redop_beat_reduce.sv
// rtl/redop_beat_reduce.sv - combinational AND/OR/XOR reduction of a single beat
module redop_beat_reduce #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    output logic              red_and,
    output logic              red_or,
    output logic              red_xor
);

    assign red_and = &data;
    assign red_or  = |data;
    assign red_xor = ^data;

endmodule

// File: rtl/redop_stream_reducer.sv
// rtl/redop_stream_reducer.sv - multi-beat streaming bit reducer; REDOP_BEAT_COUNT_EN adds res_beats
module redop_stream_reducer
    import redop_stream_reducer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_op,
    input  logic              in_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_bit,
    output logic              res_err
`ifdef REDOP_BEAT_COUNT_EN
    ,
    output logic [CNT_W-1:0]  res_beats
`endif
);

    state_t     state;
    logic [2:0] op_q;
    logic       acc_and;
    logic       acc_or;
    logic       acc_xor;

    logic       beat_and;
    logic       beat_or;
    logic       beat_xor;
    logic       accept;
    logic       first;
    logic       nxt_and;
    logic       nxt_or;
    logic       nxt_xor;
    logic [2:0] op_eff;
    logic [1:0] eval;

    redop_beat_reduce #(.DATA_W(DATA_W)) u_beat_reduce (
        .data    (in_data),
        .red_and (beat_and),
        .red_or  (beat_or),
        .red_xor (beat_xor)
    );

    assign in_ready = (state != ST_DONE);
    assign accept   = in_valid & in_ready;
    assign first    = (state == ST_IDLE);

    // The first beat seeds the accumulators rather than folding into stale values.
    assign nxt_and = first ? beat_and : (acc_and & beat_and);
    assign nxt_or  = first ? beat_or  : (acc_or  | beat_or);
    assign nxt_xor = first ? beat_xor : (acc_xor ^ beat_xor);
    assign op_eff  = first ? in_op : op_q;
    assign eval    = redop_eval(op_eff, nxt_and, nxt_or, nxt_xor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= 3'd0;
            acc_and   <= 1'b0;
            acc_or    <= 1'b0;
            acc_xor   <= 1'b0;
            res_valid <= 1'b0;
            res_bit   <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        if (first) begin
                            op_q <= in_op;
                        end
                        acc_and <= nxt_and;
                        acc_or  <= nxt_or;
                        acc_xor <= nxt_xor;
                        if (in_last) begin
                            state     <= ST_DONE;
                            res_valid <= 1'b1;
                            res_bit   <= eval[0];
                            res_err   <= eval[1];
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        res_bit   <= 1'b0;
                        res_err   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef REDOP_BEAT_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = first ? CNT_W'(1)
                   : ((cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            res_beats <= '0;
        end else if (accept) begin
            cnt_q <= cnt_nxt;
            if (in_last) begin
                res_beats <= cnt_nxt;
            end
        end else if (state == ST_DONE && res_ready) begin
            res_beats <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_redop_stream_reducer.sv
// tb/tb_redop_stream_reducer.sv - directed self-checking bench for redop_stream_reducer
module tb_redop_stream_reducer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_op;
    logic       in_last;
    logic       res_valid;
    logic       res_ready;
    logic       res_bit;
    logic       res_err;
`ifdef REDOP_BEAT_COUNT_EN
    logic [7:0] res_beats;
`endif

    int checks;
    int fails;

    redop_stream_reducer #(.DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_bit   (res_bit),
        .res_err   (res_err)
`ifdef REDOP_BEAT_COUNT_EN
        ,
        .res_beats (res_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic [2:0] op, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_op     = 3'd0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_bit", 32'(res_bit), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: AND of a single all-ones beat
        beat(8'hFF, 3'd0, 1'b1);
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_bit", 32'(res_bit), 32'd1);
        chk("t1_err", 32'(res_err), 32'd0);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        consume();
        chk("t1_valid_drop", 32'(res_valid), 32'd0);
        chk("t1_in_ready_back", 32'(in_ready), 32'd1);

        // 2: XNOR over three beats, popcount 6 -> parity 0 -> XNOR 1
        beat(8'h01, 3'd5, 1'b0);
        chk("t2_no_valid_mid", 32'(res_valid), 32'd0);
        beat(8'h03, 3'd0, 1'b0);
        beat(8'h07, 3'd2, 1'b1);
        chk("t2_valid", 32'(res_valid), 32'd1);
        chk("t2_bit", 32'(res_bit), 32'd1);
`ifdef REDOP_BEAT_COUNT_EN
        chk("t2_beats", 32'(res_beats), 32'd3);
`endif
        consume();

        // 3: NOR over two beats with a set bit -> 0; then held for 5 cycles (4)
        beat(8'h00, 3'd3, 1'b0);
        beat(8'h10, 3'd3, 1'b1);
        chk("t3_bit", 32'(res_bit), 32'd0);
`ifdef REDOP_BEAT_COUNT_EN
        chk("t3_beats", 32'(res_beats), 32'd2);
`endif
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t4_hold_valid", 32'(res_valid), 32'd1);
            chk("t4_hold_bit", 32'(res_bit), 32'd0);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume();
        chk("t4_valid_drop", 32'(res_valid), 32'd0);

        // 5: reset mid-packet, then a fresh AND packet
        beat(8'h00, 3'd0, 1'b0);
        beat(8'h00, 3'd0, 1'b0);
        reset = 1'b1;
        #2;
        chk("t5_rst_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        beat(8'hFF, 3'd0, 1'b1);
        chk("t5_valid", 32'(res_valid), 32'd1);
        chk("t5_bit", 32'(res_bit), 32'd1);
`ifdef REDOP_BEAT_COUNT_EN
        chk("t5_beats", 32'(res_beats), 32'd1);
`endif
        consume();

        // 6: illegal opcode, then a legal OR packet clears the error
        beat(8'hAA, 3'd7, 1'b1);
        chk("t6_err", 32'(res_err), 32'd1);
        chk("t6_bit", 32'(res_bit), 32'd0);
        consume();
        beat(8'h00, 3'd1, 1'b1);
        chk("t6b_err", 32'(res_err), 32'd0);
        chk("t6b_bit", 32'(res_bit), 32'd0);
        consume();

        // Extra op coverage: XOR of 8'h07 -> 1, NAND of 8'hFF -> 0
        beat(8'h07, 3'd4, 1'b1);
        chk("xor_bit", 32'(res_bit), 32'd1);
        consume();
        beat(8'hFF, 3'd2, 1'b1);
        chk("nand_bit", 32'(res_bit), 32'd0);
        consume();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
